// File: rtl/dmem_stall_ctrl_if.sv
// Data-memory request/ack bus between the MEM-stage initiator (master) and the memory (slave).
interface dmem_stall_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (output bus_req, bus_we, bus_addr, bus_wdata,
                  input  bus_ack, bus_rdata);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_wdata,
                  output bus_ack, bus_rdata);
endinterface

// File: rtl/dmem_stall_ctrl.sv
// MEM-stage data-memory initiator: issues one req/ack bus transaction per load/store and
// holds the whole pipeline via mem_stall until the access completes, errors or times out.
module dmem_stall_ctrl #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MemRead_MEM,
  input  logic               MemWrite_MEM,
  input  logic [31:0]        Addr_MEM,
  input  logic [31:0]        WD_MEM,
  output logic               mem_stall,
  output logic [31:0]        RD_MEM,
  output logic               bus_err,
  dmem_stall_ctrl_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, we_q, err_q;
  logic [31:0]   addr_q, wdata_q, rd_q;
  logic          access, misalign, timeout_hit;

  assign access      = MemRead_MEM | MemWrite_MEM;
  assign misalign    = access & (Addr_MEM[1:0] != 2'b00);
  // This WAIT cycle is the TIMEOUT-th without an ack.
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (access) state_d = misalign ? S_DONE : S_WAIT;
      S_WAIT:  if (bus.bus_ack || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_stall = ((state_q == S_IDLE) && access) || (state_q == S_WAIT);
  end

  always_comb begin
    cnt_d = '0;
    if (state_q == S_WAIT && !bus.bus_ack) cnt_d = cnt_q + CW'(1);
  end

  // Bus fields are latched on entry to WAIT and held until the transaction ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        S_IDLE: begin
          if (access && !misalign) begin
            req_q   <= 1'b1;
            we_q    <= MemWrite_MEM;
            addr_q  <= {Addr_MEM[31:2], 2'b00};
            wdata_q <= WD_MEM;
          end else if (access) begin
            err_q <= 1'b1;
            rd_q  <= ERR_DATA;
          end
        end
        S_WAIT: begin
          if (bus.bus_ack) begin
            req_q <= 1'b0;
            if (!we_q) rd_q <= bus.bus_rdata;
          end else if (timeout_hit) begin
            req_q <= 1'b0;
            err_q <= 1'b1;
            rd_q  <= ERR_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign RD_MEM        = rd_q;
  assign bus_err       = err_q;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed bench: u_a uses the default timeout, u_b uses TIMEOUT=4 for the timeout path.
module tb_dmem_stall_ctrl;
  logic        clk, rst;
  logic        rd_a, wr_a, rd_b, wr_b;
  logic [31:0] addr_a, wd_a, addr_b, wd_b;
  logic        stall_a, stall_b, err_a, err_b;
  logic [31:0] rdm_a, rdm_b;
  int          nvec, nerr;

  dmem_stall_ctrl_if bus_a ();
  dmem_stall_ctrl_if bus_b ();

  dmem_stall_ctrl u_a (
    .clk(clk), .rst(rst), .MemRead_MEM(rd_a), .MemWrite_MEM(wr_a), .Addr_MEM(addr_a),
    .WD_MEM(wd_a), .mem_stall(stall_a), .RD_MEM(rdm_a), .bus_err(err_a), .bus(bus_a));

  dmem_stall_ctrl #(.TIMEOUT(4)) u_b (
    .clk(clk), .rst(rst), .MemRead_MEM(rd_b), .MemWrite_MEM(wr_b), .Addr_MEM(addr_b),
    .WD_MEM(wd_b), .mem_stall(stall_b), .RD_MEM(rdm_b), .bus_err(err_b), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Runs one access on u_a from IDLE; acks in WAIT cycle k (k<0 never). Returns in DONE.
  task automatic xact_a(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input int k,
                        input string tag, output int stalls, output int reqs);
    int c;
    rd_a = rd; wr_a = wr; addr_a = addr; wd_a = wd; #1;
    stalls = 0; reqs = 0; c = 0;
    while (stall_a && c < 300) begin
      if (bus_a.bus_req) begin
        chk({tag, "_we"},    {31'd0, bus_a.bus_we}, {31'd0, wr});
        chk({tag, "_addr"},  bus_a.bus_addr, {addr[31:2], 2'b00});
        if (wr) chk({tag, "_wdata"}, bus_a.bus_wdata, wd);
        if (reqs == k) begin bus_a.bus_ack = 1'b1; bus_a.bus_rdata = rdata; end
        reqs++;
      end
      stalls++; c++;
      cyc();
      bus_a.bus_ack = 1'b0; bus_a.bus_rdata = 32'h0; wd_a = ~wd; #1;
    end
    if (c >= 300) chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rd_a = 0; wr_a = 0; addr_a = 0; wd_a = 0;
    rd_b = 0; wr_b = 0; addr_b = 0; wd_b = 0;
    bus_a.bus_ack = 0; bus_a.bus_rdata = 0; bus_b.bus_ack = 0; bus_b.bus_rdata = 0;
    cyc(); cyc();
    rst = 1'b0; #1;
  endtask

  initial begin
    int st, rq, c;
    nvec = 0; nerr = 0;
    do_reset();
    chk("rst_req",   {31'd0, bus_a.bus_req}, 32'd0);
    chk("rst_we",    {31'd0, bus_a.bus_we},  32'd0);
    chk("rst_addr",  bus_a.bus_addr,  32'd0);
    chk("rst_wdata", bus_a.bus_wdata, 32'd0);
    chk("rst_rd",    rdm_a, 32'd0);
    chk("rst_err",   {31'd0, err_a},   32'd0);
    chk("rst_stall", {31'd0, stall_a}, 32'd0);

    // 1: load acked in first WAIT cycle
    xact_a(1'b1, 1'b0, 32'h100, 32'h0, 32'h12345678, 0, "t1", st, rq);
    chk("t1_stalls", st, 32'd2);
    chk("t1_reqs",   rq, 32'd1);
    chk("t1_rd",     rdm_a, 32'h12345678);
    chk("t1_req_done", {31'd0, bus_a.bus_req}, 32'd0);
    rd_a = 0; cyc(); #1;
    chk("t1_idle_stall", {31'd0, stall_a}, 32'd0);

    // 2: store acked after 5 WAIT cycles
    xact_a(1'b0, 1'b1, 32'h204, 32'hCAFEF00D, 32'hBAD0BAD0, 5, "t2", st, rq);
    chk("t2_stalls", st, 32'd7);
    chk("t2_reqs",   rq, 32'd6);
    chk("t2_rd",     rdm_a, 32'h12345678);
    chk("t2_err",    {31'd0, err_a}, 32'd0);
    wr_a = 0; cyc(); #1;

    // 5: load, spurious ack in IDLE, then two back-to-back loads, spurious ack in DONE
    xact_a(1'b1, 1'b0, 32'h300, 32'h0, 32'h11111111, 0, "t5a", st, rq);
    chk("t5a_rd", rdm_a, 32'h11111111);
    rd_a = 0; cyc();
    bus_a.bus_ack = 1'b1; bus_a.bus_rdata = 32'hBADBADBA; #1;
    chk("t5_idle_stall", {31'd0, stall_a}, 32'd0);
    cyc(); bus_a.bus_ack = 1'b0; #1;
    chk("t5_idle_req", {31'd0, bus_a.bus_req}, 32'd0);
    chk("t5_idle_rd",  rdm_a, 32'h11111111);
    chk("t5_idle_err", {31'd0, err_a}, 32'd0);
    xact_a(1'b1, 1'b0, 32'h304, 32'h0, 32'h22222222, 1, "t5b", st, rq);
    chk("t5b_stalls", st, 32'd3);
    chk("t5b_reqs",   rq, 32'd2);
    chk("t5b_rd",     rdm_a, 32'h22222222);
    bus_a.bus_ack = 1'b1; bus_a.bus_rdata = 32'hBADBADBA;
    cyc(); bus_a.bus_ack = 1'b0;
    xact_a(1'b1, 1'b0, 32'h308, 32'h0, 32'h33333333, 0, "t5c", st, rq);
    chk("t5c_stalls", st, 32'd2);
    chk("t5c_reqs",   rq, 32'd1);
    chk("t5c_rd",     rdm_a, 32'h33333333);
    rd_a = 0; cyc(); #1;

    // 4: misaligned load
    xact_a(1'b1, 1'b0, 32'h102, 32'h0, 32'h0, 0, "t4", st, rq);
    chk("t4_stalls", st, 32'd1);
    chk("t4_reqs",   rq, 32'd0);
    chk("t4_rd",     rdm_a, 32'hDEADBEEF);
    chk("t4_err",    {31'd0, err_a}, 32'd1);
    rd_a = 0; cyc(); #1;

    // 3: timeout on u_b (TIMEOUT=4), then sticky error through a good access
    rd_b = 1; addr_b = 32'h40; #1;
    st = 0; rq = 0; c = 0;
    while (stall_b && c < 20) begin
      if (bus_b.bus_req) rq++;
      st++; c++;
      cyc(); #1;
    end
    chk("t3_reqs",   rq, 32'd4);
    chk("t3_stalls", st, 32'd5);
    chk("t3_req_done", {31'd0, bus_b.bus_req}, 32'd0);
    chk("t3_rd",     rdm_b, 32'hDEADBEEF);
    chk("t3_err",    {31'd0, err_b}, 32'd1);
    rd_b = 0; cyc();
    rd_b = 1; addr_b = 32'h44; cyc();
    bus_b.bus_ack = 1'b1; bus_b.bus_rdata = 32'h0000600D; #1;
    chk("t3_good_req", {31'd0, bus_b.bus_req}, 32'd1);
    cyc(); bus_b.bus_ack = 1'b0; #1;
    chk("t3_good_rd",  rdm_b, 32'h0000600D);
    chk("t3_good_err", {31'd0, err_b}, 32'd1);
    rd_b = 0; cyc(); #1;
    chk("t3_err_hold", {31'd0, err_b}, 32'd1);

    // 6: reset in WAIT cycle 2, late ack ignored
    rd_a = 1; addr_a = 32'h400; cyc(); #1;
    chk("t6_w1_req", {31'd0, bus_a.bus_req}, 32'd1);
    cyc(); rst = 1'b1; cyc();
    rst = 1'b0; bus_a.bus_ack = 1'b1; bus_a.bus_rdata = 32'h77777777; #1;
    chk("t6_req",   {31'd0, bus_a.bus_req}, 32'd0);
    chk("t6_stall_acc", {31'd0, stall_a}, 32'd1);
    chk("t6_rd",    rdm_a, 32'd0);
    chk("t6_err",   {31'd0, err_a}, 32'd0);
    chk("t6_err_b", {31'd0, err_b}, 32'd0);
    rd_a = 0; #1;
    chk("t6_stall_noacc", {31'd0, stall_a}, 32'd0);
    cyc(); bus_a.bus_ack = 1'b0; #1;
    chk("t6_late_req", {31'd0, bus_a.bus_req}, 32'd0);
    chk("t6_late_rd",  rdm_a, 32'd0);
    chk("t6_late_err", {31'd0, err_a}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
